spi_pixel_buffer: RTL and testbench

- SPI-mode-0 slave that receives full LED frames from the host MCU and stores them in a double-buffered pixel RAM.
- Serves the WS2812 driver's pixel read interface (data_request, address, then red/green/blue).
- Swaps buffers only while the driver sits in its reset/latch gap, so a frame never tears mid-chain.
- Sits directly upstream of the ws2812 block in the SPI-to-neopixel path.

---
 rtl/spi_pixel_buffer.sv | 125 ++++++++++++
 tb/tb_spi_pixel_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pixel_buffer.sv
// spi_pixel_buffer: SPI-mode-0 frame receiver with a double-buffered pixel RAM for a WS2812 driver
module spi_pixel_buffer #(
  parameter int NUM_LEDS = 4,
  parameter int SYSTEM_CLOCK = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  input  logic reset_state,
  input  logic data_request,
  input  logic [$clog2(NUM_LEDS)-1:0] address,
  output logic [7:0] red_out,
  output logic [7:0] green_out,
  output logic [7:0] blue_out,
  output logic frame_pending,
  output logic frame_error
);
  localparam int AW = $clog2(NUM_LEDS);
  localparam int FULL = NUM_LEDS * 3;
  localparam int BW = $clog2(FULL + 2);
  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
  typedef enum logic [1:0] {COL_G, COL_R, COL_B} color_t;
  if (SYSTEM_CLOCK < 8) begin : g_clock_check
    $error("SYSTEM_CLOCK too low for SPI oversampling");
  end
  state_t state, state_n;
  color_t color;
  logic [1:0] sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d, sclk_rise, cs_fall, cs_rise, cs_low;
  logic [7:0] shreg, g_byte, r_byte;
  logic [2:0] bit_cnt;
  logic byte_valid;
  logic [BW-1:0] byte_cnt;
  logic [AW-1:0] wr_led;
  logic front_sel, front_valid;
  logic full, start, take, overflow, done_ok, done_bad, wr_en, swap, rd_ok;
  logic [23:0] mem [2][NUM_LEDS];
  // SPI lines are asynchronous: two-stage synchronisers plus one history stage for edge detection
  always_ff @(posedge clk) begin
    sclk_s <= {sclk_s[0], spi_sclk};
    cs_s <= {cs_s[0], spi_cs_n};
    mosi_s <= {mosi_s[0], spi_mosi};
    sclk_d <= sclk_s[1];
    cs_d <= cs_s[1];
  end
  assign cs_low = ~cs_s[1];
  assign sclk_rise = sclk_s[1] & ~sclk_d;
  assign cs_fall = ~cs_s[1] & cs_d;
  assign cs_rise = cs_s[1] & ~cs_d;
  assign full = byte_cnt == BW'(FULL);
  assign start = state == IDLE && cs_fall;
  assign done_ok = state == RECV && cs_rise && full && bit_cnt == 3'd0;
  assign done_bad = state == RECV && cs_rise && !done_ok;
  assign take = state == RECV && !cs_rise && byte_valid && !full;
  assign overflow = state == RECV && !cs_rise && byte_valid && full;
  assign wr_en = take && color == COL_B;
  assign swap = frame_pending && reset_state && !data_request && !start;
  assign rd_ok = front_valid && 32'(address) < NUM_LEDS;
  // shift MOSI in on every SCLK rise inside chip select and flag each completed byte
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= sclk_rise && cs_low && bit_cnt == 3'd7;
      if (sclk_rise && cs_low) shreg <= {shreg[6:0], mosi_s[1]};
      bit_cnt <= start ? 3'd0 : (sclk_rise && cs_low) ? bit_cnt + 3'd1 : bit_cnt;
    end
  end
  // write FSM next state: a byte past the end of the frame parks the FSM until chip select rises
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = cs_fall ? RECV : IDLE;
      RECV: state_n = cs_rise ? IDLE : overflow ? DROP : RECV;
      DROP: state_n = cs_rise ? IDLE : DROP;
      default: state_n = IDLE;
    endcase
  end
  // frame bookkeeping, status flags and buffer swap during the driver's latch gap
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      color <= COL_G;
      byte_cnt <= '0;
      wr_led <= '0;
      frame_pending <= 1'b0;
      frame_error <= 1'b0;
      front_sel <= 1'b0;
      front_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (start) begin
        color <= COL_G;
        byte_cnt <= '0;
        wr_led <= '0;
      end else if (take) begin
        byte_cnt <= byte_cnt + BW'(1);
        color <= color == COL_G ? COL_R : color == COL_R ? COL_B : COL_G;
        if (color == COL_B) wr_led <= wr_led + AW'(1);
      end else if (overflow) begin
        byte_cnt <= BW'(FULL + 1);
      end
      frame_pending <= start ? 1'b0 : done_ok ? 1'b1 : swap ? 1'b0 : frame_pending;
      frame_error <= frame_error | overflow | done_bad;
      if (swap) begin
        front_sel <= ~front_sel;
        front_valid <= 1'b1;
      end
    end
  end
  // hold G and R until B arrives, then write the whole pixel into the back buffer
  always_ff @(posedge clk) begin
    if (take && color == COL_G) g_byte <= shreg;
    if (take && color == COL_R) r_byte <= shreg;
    if (wr_en) mem[~front_sel][wr_led] <= {g_byte, r_byte, shreg};
  end
  // registered pixel read from the front buffer, black when no frame is shown yet
  always_ff @(posedge clk) begin
    if (reset) {green_out, red_out, blue_out} <= '0;
    else if (data_request) {green_out, red_out, blue_out} <= rd_ok ? mem[front_sel][address] : 24'd0;
  end
endmodule

// File: tb/tb_spi_pixel_buffer.sv
// tb_spi_pixel_buffer: randomized scoreboard bench against a frame-level reference model
module tb_spi_pixel_buffer;
  localparam int N = 4;
  localparam int HP = 50;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spi_sclk = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic reset_state = 1'b0;
  logic data_request = 1'b0;
  logic [1:0] address = 2'd0;
  logic [7:0] red_out, green_out, blue_out;
  logic frame_pending, frame_error;
  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic [7:0] tx[$];
  logic [23:0] front_m[N];
  logic [23:0] back_m[N];
  logic [23:0] e_mon;
  bit fv_m, pend_m, err_m;

  always #5 clk = ~clk;

  spi_pixel_buffer #(.NUM_LEDS(N), .SYSTEM_CLOCK(50000000)) dut (
    .clk(clk),
    .reset(reset),
    .spi_sclk(spi_sclk),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .reset_state(reset_state),
    .data_request(data_request),
    .address(address),
    .red_out(red_out),
    .green_out(green_out),
    .blue_out(blue_out),
    .frame_pending(frame_pending),
    .frame_error(frame_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  always begin
    @(posedge clk);
    if (data_request) begin
      #1;
      chk("read_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e_mon = exp_q.pop_front();
        chk("green_out", 32'(green_out), 32'(e_mon[23:16]));
        chk("red_out", 32'(red_out), 32'(e_mon[15:8]));
        chk("blue_out", 32'(blue_out), 32'(e_mon[7:0]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      #HP spi_sclk = 1'b1;
      #HP spi_sclk = 1'b0;
    end
  endtask

  task automatic fill(input int n, input bit directed);
    for (int k = 0; k < n; k++)
      tx.push_back(directed ? 8'(16 * (k % 3 + 1) + k / 3) : 8'($urandom));
  endtask

  task automatic send_tx();
    int n;
    n = tx.size();
    spi_cs_n = 1'b0;
    #(2 * HP);
    foreach (tx[k]) spi_byte(tx[k]);
    #HP spi_cs_n = 1'b1;
    tick(8);
    pend_m = 0;
    for (int k = 0; k + 2 < n && k < 3 * N; k += 3) back_m[k / 3] = {tx[k], tx[k + 1], tx[k + 2]};
    if (n == 3 * N) pend_m = 1;
    else err_m = 1;
    tx.delete();
  endtask

  task automatic model_swap();
    logic [23:0] t;
    if (pend_m) begin
      for (int k = 0; k < N; k++) begin
        t = front_m[k];
        front_m[k] = back_m[k];
        back_m[k] = t;
      end
      fv_m = 1;
      pend_m = 0;
    end
  endtask

  task automatic swap_window();
    reset_state = 1'b1;
    tick(4);
    reset_state = 1'b0;
    tick(1);
    model_swap();
  endtask

  task automatic read(input int a);
    data_request = 1'b1;
    address = 2'(a);
    exp_q.push_back(fv_m ? front_m[a] : 24'd0);
    tick(1);
    data_request = 1'b0;
    tick(1);
  endtask

  task automatic read_all();
    for (int a = 0; a < N; a++) read(a);
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_pending"}, 32'(frame_pending), 32'(pend_m));
    chk({tag, "_error"}, 32'(frame_error), 32'(err_m));
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_rgb"}, 32'({green_out, red_out, blue_out}), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    fv_m = 0;
    pend_m = 0;
    err_m = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    fv_m = 0;
    pend_m = 0;
    err_m = 0;
    tick(4);
    reset = 1'b0;
    tick(2);
    chk_outs_zero("reset");
    chk_flags("reset");
    read(2);
    fill(12, 1'b1);
    send_tx();
    chk_flags("frame1");
    swap_window();
    chk_flags("frame1_swap");
    read_all();
    fill(12, 1'b0);
    send_tx();
    chk_flags("deferred");
    read_all();
    reset_state = 1'b1;
    data_request = 1'b1;
    address = 2'd1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(front_m[1]);
      tick(1);
    end
    chk_flags("held_by_request");
    data_request = 1'b0;
    tick(3);
    reset_state = 1'b0;
    model_swap();
    chk_flags("deferred_swap");
    read_all();
    for (int f = 0; f < 4; f++) begin
      fill(12, 1'b0);
      send_tx();
      chk_flags("random");
      swap_window();
      for (int r = 0; r < 3; r++) read($urandom_range(0, N - 1));
    end
    fill(11, 1'b0);
    send_tx();
    chk_flags("short");
    swap_window();
    read_all();
    fill(13, 1'b0);
    send_tx();
    chk_flags("long");
    swap_window();
    chk_flags("long_swap");
    read_all();
    do_reset();
    chk_outs_zero("reset2");
    chk_flags("reset2");
    read(1);
    spi_cs_n = 1'b0;
    #(2 * HP);
    for (int k = 0; k < 5; k++) spi_byte(8'($urandom));
    @(negedge clk);
    do_reset();
    for (int k = 0; k < 2; k++) spi_byte(8'($urandom));
    #HP spi_cs_n = 1'b1;
    tick(8);
    chk_flags("mid_reset");
    fill(12, 1'b1);
    send_tx();
    chk_flags("after_reset");
    swap_window();
    read_all();
    tick(3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
